apb_completer_regs: RTL and testbench
=====================================

Name: apb_completer_regs

Overview:
- APB completer (slave) that sits directly downstream of the team's IDLE/SETUP/ACCESS APB requester FSM.
- Consumes PSEL/PENABLE/PWRITE/PADDR/PWDATA and answers with PREADY/PRDATA/PSLVERR.
- Backs the bus with a small word-addressed register bank.
- Inserts a parameterised number of wait states and flags protocol violations by the requester.

Parameters:
- ADDR_W, 8, paddr width in bits
- DATA_W, 32, data width; also the register width
- NUM_REGS, 4, number of registers in the bank; word-aligned index = paddr[ADDR_W-1:2]
- WAIT_CYCLES, 1, ACCESS cycles held with pready=0 before pready=1 (0 = zero-wait)

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- psel  in  1  completer selected
- penable  in  1  access phase
- pwrite  in  1  1=write, 0=read
- paddr  in  ADDR_W  byte address
- pwdata  in  DATA_W  write data
- pready  out  1  transfer completes this cycle
- prdata  out  DATA_W  read data, valid when pready && !pwrite
- pslverr  out  1  error response, valid only with pready
- regs_flat  out  NUM_REGS*DATA_W  register contents; reg i at bits [i*DATA_W +: DATA_W]
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async, resetn=0):
  - state=C_IDLE, wait_cnt=0, all registers=0, proto_err=0.
  - pready=0, prdata=0, pslverr=0 immediately, independent of clk.
  - Reset mid-transfer aborts it: no write occurs, outputs drop at once.
- FSM states: C_IDLE, C_ACCESS.
- C_IDLE:
  - psel&&!penable sampled -> C_ACCESS, wait_cnt=0.
  - psel&&penable sampled -> proto_err=1, stay C_IDLE, no register effect.
- C_ACCESS:
  - pready = (wait_cnt==WAIT_CYCLES), combinational from state and counter.
  - psel&&penable && !pready -> wait_cnt+1.
  - psel&&penable && pready -> transfer completes; next state C_IDLE.
  - psel==0 or penable==0 before completion -> abort, C_IDLE, proto_err=1, no write.
- Latency: a transfer completes in the (WAIT_CYCLES+1)-th ACCESS cycle, i.e. SETUP + 1 + WAIT_CYCLES cycles total.
- Back-to-back transfers:
  - SETUP in the cycle right after completion is seen from C_IDLE. No dead cycle is required beyond the APB SETUP phase.
- Address decode:
  - err = (paddr[1:0]!=0) || (paddr[ADDR_W-1:2] >= NUM_REGS).
  - pslverr = pready && err. Outside the completing cycle pslverr=0.
- Write:
  - On the completing edge with pwrite && !err: reg[idx] <= pwdata.
  - On error: no register changes.
- Read:
  - prdata = reg[idx] when pready && !pwrite && !err; otherwise 0.
  - Registers are stable during the transfer, so prdata reflects the pre-write value.
- pwdata, paddr and pwrite may change during wait states (illegal per APB). The completer uses the values present on the completing cycle and does not flag this.
- wait_cnt width is clog2(WAIT_CYCLES+1); no wrap is possible because it clears on entry to C_ACCESS.
- proto_err clears only on reset.

Decomposition:
- Package apb_pkg:
  - typedef enum logic [0:0] apb_cmp_state_e {C_IDLE, C_ACCESS}.
  - Shared with the requester: the enum {IDLE, SETUP, ACCESS} and default ADDR_W/DATA_W localparams.
- Sub-module apb_regbank: NUM_REGS×DATA_W flops, async reset, one write port (we, idx, wdata), combinational read port, flat output.
- The FSM, wait counter, decode and error logic stay in apb_completer_regs.

Test Plan:
- WAIT_CYCLES=1: write 0xDEADBEEF to paddr=0x04 -> pready low in the 1st ACCESS cycle and high in the 2nd; regs_flat[63:32]=0xDEADBEEF after that edge; pslverr=0.
- Read paddr=0x04 after that write -> prdata=0xDEADBEEF exactly in the pready cycle, 0 elsewhere.
- WAIT_CYCLES=0: back-to-back writes to 0x00 (0x1), 0x08 (0x2), then read 0x00 -> each completes in its first ACCESS cycle; read returns 0x1, reg2=0x2.
- Out-of-range paddr=0x10 write and misaligned paddr=0x05 read -> pslverr=1 with pready; prdata=0; all registers unchanged.
- Requester drops psel mid-wait (WAIT_CYCLES=3, after 1 ACCESS cycle) -> no write, proto_err=1 and sticky. penable=1 without SETUP from idle -> proto_err=1.
- resetn pulled low during a write's wait state -> pready/pslverr/prdata=0 and regs=0 without a clock edge. After release, a new transfer completes normally.

Source files
------------

// File: rtl/apb_completer_regs_pkg.sv
// ============================================================================
// Module   : apb_pkg
// Brief    : Shared APB types and defaults for the requester/completer pair.
// Revision : 1.0
// ============================================================================
`default_nettype none

package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_req_state_e;

    typedef enum logic [0:0] {
        C_IDLE,
        C_ACCESS
    } apb_cmp_state_e;

endpackage

`default_nettype wire

// File: rtl/apb_completer_regs_if.sv
// ============================================================================
// Module   : apb_completer_regs_if
// Brief    : APB bus bundle with requester (master) and completer (slave) views.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface apb_completer_regs_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

`default_nettype wire

// File: rtl/apb_completer_regs_regbank.sv
// ============================================================================
// Module   : apb_regbank
// Brief    : NUM_REGS x DATA_W register file, one write port, async read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb_regbank
    import apb_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = APB_DATA_W,
    parameter int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  wire logic                       clk,
    input  wire logic                       resetn,
    input  wire logic                       we,
    input  wire logic [IDX_W-1:0]           idx,
    input  wire logic [DATA_W-1:0]          wdata,
    output logic      [DATA_W-1:0]          rdata,
    output logic      [NUM_REGS*DATA_W-1:0] regs_flat
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we) begin
            r_regs[idx] <= wdata;
        end
    end

    assign rdata = r_regs[idx];

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign regs_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
    end

endmodule

`default_nettype wire

// File: rtl/apb_completer_regs.sv
// ============================================================================
// Module   : apb_completer_regs
// Brief    : APB completer with wait-state insertion, address decode and a
//            sticky requester protocol-violation flag, backed by apb_regbank.
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb_completer_regs
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int NUM_REGS    = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic                       clk,
    input  wire logic                       resetn,
    apb_completer_regs_if.slave             bus,
    output logic      [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                            proto_err
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] c_WAIT = CNT_W'(WAIT_CYCLES);

    apb_cmp_state_e     r_state;
    apb_cmp_state_e     w_state_nxt;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]   w_wait_cnt_nxt;
    logic               r_proto_err;
    logic               w_proto_err_nxt;

    logic [ADDR_W-3:0]  w_word;
    logic [IDX_W-1:0]   w_idx;
    logic               w_err;
    logic               w_pready;
    logic               w_access;
    logic               w_we;
    logic [DATA_W-1:0]  w_rdata;

    assign w_word   = bus.paddr[ADDR_W-1:2];
    assign w_idx    = w_word[IDX_W-1:0];
    assign w_err    = (bus.paddr[1:0] != 2'b00) || (int'(w_word) >= NUM_REGS);
    assign w_access = bus.psel && bus.penable;
    assign w_pready = (r_state == C_ACCESS) && (r_wait_cnt == c_WAIT);

    // Commit only on a genuine completing cycle; an abort on that cycle must not write.
    assign w_we = w_pready && w_access && bus.pwrite && !w_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= C_IDLE;
            r_wait_cnt  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_proto_err_nxt = r_proto_err;
        unique case (r_state)
            C_IDLE: begin
                if (bus.psel && !bus.penable) begin
                    w_state_nxt    = C_ACCESS;
                    w_wait_cnt_nxt = '0;
                end else if (w_access) begin
                    w_proto_err_nxt = 1'b1;
                end
            end
            C_ACCESS: begin
                if (w_access) begin
                    if (w_pready) begin
                        w_state_nxt = C_IDLE;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                    end
                end else begin
                    w_state_nxt     = C_IDLE;
                    w_proto_err_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = C_IDLE;
            end
        endcase
    end

    apb_regbank #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) u_regbank (
        .clk       (clk),
        .resetn    (resetn),
        .we        (w_we),
        .idx       (w_idx),
        .wdata     (bus.pwdata),
        .rdata     (w_rdata),
        .regs_flat (regs_flat)
    );

    assign bus.pready  = w_pready;
    assign bus.pslverr = w_pready && w_err;
    assign bus.prdata  = (w_pready && !bus.pwrite && !w_err) ? w_rdata : '0;
    assign proto_err   = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_apb_completer_regs.sv
// ============================================================================
// Module   : tb_apb_completer_regs
// Brief    : Scoreboard bench for apb_completer_regs at WAIT_CYCLES = 1, 0, 3.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_apb_completer_regs;

    logic              clk = 1'b0;
    logic              resetn;
    logic [2:0]        psel, penable, pwrite;
    logic [7:0]        paddr  [3];
    logic [31:0]       pwdata [3];
    logic [2:0]        pready, pslverr, proto_err;
    logic [31:0]       prdata    [3];
    logic [127:0]      regs_flat [3];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    // Instance 0: WAIT_CYCLES=1, instance 1: WAIT_CYCLES=0, instance 2: WAIT_CYCLES=3
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int W = (gi == 0) ? 1 : (gi == 1) ? 0 : 3;
        logic [127:0] rf;
        logic         pe;
        apb_completer_regs_if #(.ADDR_W(8), .DATA_W(32)) bus ();
        assign bus.psel    = psel[gi];
        assign bus.penable = penable[gi];
        assign bus.pwrite  = pwrite[gi];
        assign bus.paddr   = paddr[gi];
        assign bus.pwdata  = pwdata[gi];
        assign pready[gi]  = bus.pready;
        assign pslverr[gi] = bus.pslverr;
        assign prdata[gi]  = bus.prdata;
        assign regs_flat[gi] = rf;
        assign proto_err[gi] = pe;
        apb_completer_regs #(
            .ADDR_W(8), .DATA_W(32), .NUM_REGS(4), .WAIT_CYCLES(W)
        ) u_dut (
            .clk       (clk),
            .resetn    (resetn),
            .bus       (bus.slave),
            .regs_flat (rf),
            .proto_err (pe)
        );
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        psel = '0; penable = '0;
    endtask

    task automatic xfer(input int i, input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input bit exp_err, input int waits,
                        input string name);
        exp_t e;
        e.inst = i; e.rdata = exp_rd; e.err = exp_err; e.name = name;
        sb_q.push_back(e);
        @(posedge clk); #1;
        psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = wr; paddr[i] = a; pwdata[i] = d;
        @(posedge clk); #1;
        penable[i] = 1'b1;
        for (int k = 0; k < waits; k++) begin
            @(negedge clk);
            chk({name, "_wait_pready"}, pready[i], 1'b0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk({name, "_pready"}, pready[i], 1'b1);
    endtask

    // Monitor: every completing cycle pops the scoreboard; otherwise outputs must be quiet.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (pready[i] === 1'b1) begin
                    chk("sb_has_entry", (sb_q.size() != 0), 1'b1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        chk({e.name, "_inst"}, i, e.inst);
                        chk({e.name, "_prdata"}, prdata[i], e.rdata);
                        chk({e.name, "_pslverr"}, pslverr[i], e.err);
                    end
                end else begin
                    chk("idle_prdata", prdata[i], 32'h0);
                    chk("idle_pslverr", pslverr[i], 1'b0);
                end
            end
        end
    end

    initial begin
        resetn = 1'b0;
        psel = '0; penable = '0; pwrite = '0;
        for (int i = 0; i < 3; i++) begin
            paddr[i] = '0; pwdata[i] = '0;
        end
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_pready", pready[i], 1'b0);
            chk("rst_prdata", prdata[i], 32'h0);
            chk("rst_pslverr", pslverr[i], 1'b0);
            chk("rst_regs", regs_flat[i], 128'h0);
            chk("rst_proto_err", proto_err[i], 1'b0);
        end
        #10 resetn = 1'b1;

        // WAIT_CYCLES=1: write then read back
        xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 32'h0, 1'b0, 1, "w1_wr04");
        go_idle();
        chk("w1_reg1", regs_flat[0][63:32], 32'hDEADBEEF);
        xfer(0, 1'b0, 8'h04, 32'h0, 32'hDEADBEEF, 1'b0, 1, "w1_rd04");
        go_idle();

        // WAIT_CYCLES=0: back-to-back transfers
        xfer(1, 1'b1, 8'h00, 32'h1, 32'h0, 1'b0, 0, "w0_wr00");
        xfer(1, 1'b1, 8'h08, 32'h2, 32'h0, 1'b0, 0, "w0_wr08");
        xfer(1, 1'b0, 8'h00, 32'h0, 32'h1, 1'b0, 0, "w0_rd00");
        go_idle();
        chk("w0_regs", regs_flat[1], {32'h0, 32'h2, 32'h0, 32'h1});

        // Decode errors
        xfer(1, 1'b1, 8'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 0, "w0_wr10_oor");
        go_idle();
        xfer(1, 1'b0, 8'h05, 32'h0, 32'h0, 1'b1, 0, "w0_rd05_mis");
        go_idle();
        xfer(1, 1'b0, 8'h01, 32'h0, 32'h0, 1'b1, 0, "w0_rd01_mis");
        go_idle();
        chk("w0_regs_after_err", regs_flat[1], {32'h0, 32'h2, 32'h0, 32'h1});
        chk("w0_no_proto_err", proto_err[1], 1'b0);

        // WAIT_CYCLES=3: requester drops psel after one ACCESS cycle
        @(posedge clk); #1;
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'h04; pwdata[2] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        penable[2] = 1'b1;
        @(negedge clk);
        chk("w3_abort_pready", pready[2], 1'b0);
        @(posedge clk); #1;
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("w3_abort_proto_err", proto_err[2], 1'b1);
        chk("w3_abort_regs", regs_flat[2], 128'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("w3_proto_err_sticky", proto_err[2], 1'b1);
        xfer(2, 1'b1, 8'h0C, 32'h12345678, 32'h0, 1'b0, 3, "w3_wr0c");
        go_idle();
        chk("w3_reg3", regs_flat[2], {32'h12345678, 96'h0});
        chk("w3_proto_err_kept", proto_err[2], 1'b1);

        // penable without SETUP from idle
        chk("w1_proto_err_pre", proto_err[0], 1'b0);
        @(posedge clk); #1;
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 8'h00; pwdata[0] = 32'h55;
        @(posedge clk); #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge clk);
        chk("w1_nosetup_proto_err", proto_err[0], 1'b1);
        chk("w1_nosetup_regs", regs_flat[0], {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});

        // Async reset in the wait state of a WAIT_CYCLES=3 write
        @(posedge clk); #1;
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'h08; pwdata[2] = 32'hCAFEF00D;
        @(posedge clk); #1;
        penable[2] = 1'b1;
        @(posedge clk); #1;
        #1 resetn = 1'b0;
        #1;
        chk("rst_mid_pready", pready[2], 1'b0);
        chk("rst_mid_pslverr", pslverr[2], 1'b0);
        chk("rst_mid_prdata", prdata[2], 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("rst_mid_regs", regs_flat[i], 128'h0);
            chk("rst_mid_proto_err", proto_err[i], 1'b0);
        end
        psel = '0; penable = '0;
        #1 resetn = 1'b1;
        xfer(2, 1'b1, 8'h08, 32'hCAFEF00D, 32'h0, 1'b0, 3, "w3_wr08_post");
        go_idle();
        xfer(2, 1'b0, 8'h08, 32'h0, 32'hCAFEF00D, 1'b0, 3, "w3_rd08_post");
        go_idle();
        chk("w3_regs_post", regs_flat[2], {32'h0, 32'hCAFEF00D, 64'h0});
        chk("w3_proto_err_post", proto_err[2], 1'b0);

        // Async reset while a WAIT_CYCLES=1 read presents pready
        xfer(0, 1'b1, 8'h00, 32'h11, 32'h0, 1'b0, 1, "w1_wr00");
        go_idle();
        @(posedge clk); #1;
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 8'h00;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        @(posedge clk); #1;
        chk("w1_pre_rst_prdata", prdata[0], 32'h11);
        #1 resetn = 1'b0;
        #1;
        chk("rst_rd_pready", pready[0], 1'b0);
        chk("rst_rd_prdata", prdata[0], 32'h0);
        chk("rst_rd_regs", regs_flat[0], 128'h0);
        psel = '0; penable = '0;
        #1 resetn = 1'b1;

        repeat (3) @(posedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
